// File: rtl/alu_simd_pipelined_param.sv
// ---------------------------------------------------------------------------
// alu_simd_pipelined_param
//
// Segmented SIMD ALU. The N-bit word is built from NUM_SEG segments of SEG_W
// bits. The mode input selects how many lanes the word is split into
// (2^mode lanes). Carries ripple between segments inside a lane and stop at
// lane boundaries. An optional input register stage (REG_IN) gives a
// latency of 2; without it the latency is 1. The output stage is the only
// writer of S, and S also feeds the accumulator, so back-to-back acc
// transactions chain without bubbles.
//
// Ports
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset, takes priority over ce
//   ce         : clock enable for every register
//   in_valid   : the current input set is a transaction
//   mode       : SIMD split (2^mode lanes); illegal values act as mode 0
//   op         : 000 add, 001 sub, 010 xor, 011 and, 100 or, 101 acc
//   X, Y, Z    : operands
//   CIN        : carry into lane 0
//   acc_clr    : zero the accumulator seed and clear the sticky flags
//   out_valid  : S / carry_out / mode_err hold a freshly completed result
//   S          : registered result
//   carry_out  : lane carry/borrow at each lane's top segment index
//   ovf_sticky : sticky lane carry for add/acc, same positions
//   mode_err   : the result came from an illegal mode
// ---------------------------------------------------------------------------
module alu_simd_pipelined_param #(
    parameter int unsigned SEG_W   = 4,
    parameter int unsigned NUM_SEG = 8,
    parameter int unsigned REG_IN  = 1,
    localparam int unsigned N      = SEG_W * NUM_SEG,
    localparam int unsigned MODE_W = $clog2(NUM_SEG) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic               in_valid,
    input  logic [MODE_W-1:0]  mode,
    input  logic [2:0]         op,
    input  logic [N-1:0]       X,
    input  logic [N-1:0]       Y,
    input  logic [N-1:0]       Z,
    input  logic               CIN,
    input  logic               acc_clr,
    output logic               out_valid,
    output logic [N-1:0]       S,
    output logic [NUM_SEG-1:0] carry_out,
    output logic [NUM_SEG-1:0] ovf_sticky,
    output logic               mode_err
);

    localparam int unsigned LOG_SEG = $clog2(NUM_SEG);

    typedef enum logic [2:0] {
        OpAdd  = 3'b000,
        OpSub  = 3'b001,
        OpXor  = 3'b010,
        OpAnd  = 3'b011,
        OpOr   = 3'b100,
        OpAcc  = 3'b101,
        OpRsv6 = 3'b110,
        OpRsv7 = 3'b111
    } op_e;

    // A transaction carries its controls with its data, so controls may
    // change every cycle without disturbing anything in flight.
    typedef struct packed {
        logic              valid;
        logic [MODE_W-1:0] mode;
        op_e               op;
        logic              cin;
        logic              acc_clr;
        logic [N-1:0]      x;
        logic [N-1:0]      y;
        logic [N-1:0]      z;
    } txn_t;

    txn_t in_txn;
    txn_t st_txn;

    always_comb begin
        in_txn         = '0;
        in_txn.valid   = in_valid;
        in_txn.mode    = mode;
        in_txn.op      = op_e'(op);
        in_txn.cin     = CIN;
        in_txn.acc_clr = acc_clr;
        in_txn.x       = X;
        in_txn.y       = Y;
        in_txn.z       = Z;
    end

    // ------------------------------------------------------------------
    // Optional input register stage
    // ------------------------------------------------------------------
    generate
        if (REG_IN != 0) begin : g_in_reg
            txn_t txn_d;
            txn_t txn_q;

            always_comb begin
                txn_d = txn_q;
                if (reset) begin
                    // Drops whatever is in flight and whatever arrives now.
                    txn_d = '0;
                end else if (ce) begin
                    txn_d = in_txn;
                end
            end

            always_ff @(posedge clk) begin
                txn_q <= txn_d;
            end

            assign st_txn = txn_q;
        end else begin : g_in_bypass
            assign st_txn = in_txn;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output stage registers
    // ------------------------------------------------------------------
    logic               out_valid_d, out_valid_q;
    logic [N-1:0]       s_d, s_q;
    logic [NUM_SEG-1:0] carry_out_d, carry_out_q;
    logic [NUM_SEG-1:0] sticky_d, sticky_q;
    logic               mode_err_d, mode_err_q;

    // ------------------------------------------------------------------
    // Segmented datapath
    // ------------------------------------------------------------------
    logic               mode_err_c;
    logic [MODE_W-1:0]  eff_mode;
    int unsigned        lane_mask;
    logic [N-1:0]       p_val;
    logic [N-1:0]       res_c;
    logic [NUM_SEG-1:0] carry_c;
    logic               is_arith;
    logic [1:0]         chain;
    logic [1:0]         seg_cin;
    logic [SEG_W-1:0]   seg_a;
    logic [SEG_W-1:0]   seg_x;
    logic [SEG_W-1:0]   seg_y;
    logic [SEG_W+1:0]   seg_sum;

    always_comb begin
        mode_err_c = (st_txn.mode > MODE_W'(LOG_SEG));
        eff_mode   = mode_err_c ? '0 : st_txn.mode;
        // Segments per lane is a power of two, so a mask finds lane edges.
        lane_mask  = (NUM_SEG >> eff_mode) - 1;
        p_val      = st_txn.acc_clr ? '0 : s_q;
        is_arith   = (st_txn.op == OpAdd) || (st_txn.op == OpSub) || (st_txn.op == OpAcc);
        res_c      = '0;
        carry_c    = '0;
        chain      = '0;
        seg_cin    = '0;
        seg_a      = '0;
        seg_x      = '0;
        seg_y      = '0;
        seg_sum    = '0;

        for (int unsigned i = 0; i < NUM_SEG; i++) begin
            seg_x = st_txn.x[i*SEG_W +: SEG_W];
            seg_y = st_txn.y[i*SEG_W +: SEG_W];
            seg_a = (st_txn.op == OpAcc) ? p_val[i*SEG_W +: SEG_W] : st_txn.z[i*SEG_W +: SEG_W];

            if ((i & lane_mask) == 0) begin
                seg_cin = (i == 0) ? {1'b0, st_txn.cin} : 2'b00;
            end else begin
                seg_cin = chain;
            end

            // Three operands plus carry: the inter-segment carry/borrow is
            // 0..2, hence the two extra bits.
            if (st_txn.op == OpSub) begin
                seg_sum = {2'b00, seg_a} - {2'b00, seg_x} - {2'b00, seg_y}
                        - {{SEG_W{1'b0}}, seg_cin};
                // Upper bits are the negated borrow in two's complement.
                chain   = ~seg_sum[SEG_W+1:SEG_W] + 2'd1;
            end else begin
                seg_sum = {2'b00, seg_a} + {2'b00, seg_x} + {2'b00, seg_y}
                        + {{SEG_W{1'b0}}, seg_cin};
                chain   = seg_sum[SEG_W+1:SEG_W];
            end

            res_c[i*SEG_W +: SEG_W] = seg_sum[SEG_W-1:0];

            if (is_arith && ((i & lane_mask) == lane_mask)) begin
                carry_c[i] = (chain != 2'b00);
            end
        end

        case (st_txn.op)
            OpXor:   res_c = st_txn.x ^ st_txn.z;
            OpAnd:   res_c = st_txn.x & st_txn.z;
            OpOr:    res_c = st_txn.x | st_txn.z;
            OpRsv6,
            OpRsv7:  res_c = '0;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Output stage next state
    // ------------------------------------------------------------------
    always_comb begin
        out_valid_d = out_valid_q;
        s_d         = s_q;
        carry_out_d = carry_out_q;
        sticky_d    = sticky_q;
        mode_err_d  = mode_err_q;

        if (reset) begin
            out_valid_d = 1'b0;
            s_d         = '0;
            carry_out_d = '0;
            sticky_d    = '0;
            mode_err_d  = 1'b0;
        end else if (ce) begin
            out_valid_d = st_txn.valid;
            if (st_txn.valid) begin
                s_d         = res_c;
                carry_out_d = carry_c;
                mode_err_d  = mode_err_c;
                // Clear first, then OR in new carries so a set wins.
                sticky_d    = (st_txn.acc_clr ? '0 : sticky_q)
                            | (((st_txn.op == OpAdd) || (st_txn.op == OpAcc)) ? carry_c : '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        out_valid_q <= out_valid_d;
        s_q         <= s_d;
        carry_out_q <= carry_out_d;
        sticky_q    <= sticky_d;
        mode_err_q  <= mode_err_d;
    end

    assign out_valid  = out_valid_q;
    assign S          = s_q;
    assign carry_out  = carry_out_q;
    assign ovf_sticky = sticky_q;
    assign mode_err   = mode_err_q;

endmodule

// File: tb/tb_alu_simd_pipelined_param.sv
// ---------------------------------------------------------------------------
// tb_alu_simd_pipelined_param
//
// Directed and randomized stimulus for alu_simd_pipelined_param at default
// parameters (SEG_W=4, NUM_SEG=8, REG_IN=1). A lane-level arithmetic model
// tracks the expected output registers; every cycle all outputs are
// compared, and the documented example vectors are also checked against
// fixed constants.
// ---------------------------------------------------------------------------
module tb_alu_simd_pipelined_param;

    localparam int SEG_W   = 4;
    localparam int NUM_SEG = 8;
    localparam int N       = 32;
    localparam int MODE_W  = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               ce;
    logic               in_valid;
    logic [MODE_W-1:0]  mode;
    logic [2:0]         op;
    logic [N-1:0]       x_in, y_in, z_in;
    logic               cin;
    logic               acc_clr;
    logic               out_valid;
    logic [N-1:0]       s_out;
    logic [NUM_SEG-1:0] carry_out;
    logic [NUM_SEG-1:0] ovf_sticky;
    logic               mode_err;

    alu_simd_pipelined_param #(
        .SEG_W  (SEG_W),
        .NUM_SEG(NUM_SEG),
        .REG_IN (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .in_valid  (in_valid),
        .mode      (mode),
        .op        (op),
        .X         (x_in),
        .Y         (y_in),
        .Z         (z_in),
        .CIN       (cin),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .S         (s_out),
        .carry_out (carry_out),
        .ovf_sticky(ovf_sticky),
        .mode_err  (mode_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit              valid;
        int unsigned     mode;
        int unsigned     op;
        longint unsigned x;
        longint unsigned y;
        longint unsigned z;
        bit              cin;
        bit              clr;
    } txn_t;

    // Expected state of the output registers and the one transaction held
    // in the input stage.
    longint unsigned m_s;
    bit [7:0]        m_co;
    bit [7:0]        m_sticky;
    bit              m_err;
    bit              m_vld;
    txn_t            held;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Result of one transaction computed lane by lane with plain integers.
    task automatic apply(input txn_t t);
        int unsigned     m, lane_bits, spl;
        longint unsigned modv, mask, xv, yv, zv, pv, sum, r, res;
        bit              c;
        bit              cl;
        bit [7:0]        co;
        m         = (t.mode > 3) ? 0 : t.mode;
        lane_bits = 32 >> m;
        spl       = 8 >> m;
        modv      = 64'd1 << lane_bits;
        mask      = modv - 1;
        res       = 0;
        co        = '0;
        for (int k = 0; k < (1 << m); k++) begin
            xv = (t.x >> (k * lane_bits)) & mask;
            yv = (t.y >> (k * lane_bits)) & mask;
            zv = (t.z >> (k * lane_bits)) & mask;
            pv = t.clr ? 0 : ((m_s >> (k * lane_bits)) & mask);
            cl = (k == 0) ? t.cin : 1'b0;
            r  = 0;
            c  = 1'b0;
            case (t.op)
                0: begin sum = zv + xv + yv + cl; r = sum % modv; c = (sum >= modv); end
                1: begin sum = xv + yv + cl; r = (zv + 4 * modv - sum) % modv; c = (zv < sum); end
                5: begin sum = pv + xv + yv + cl; r = sum % modv; c = (sum >= modv); end
                default: ;
            endcase
            res = res | (r << (k * lane_bits));
            if (c) co[k * spl + spl - 1] = 1'b1;
        end
        case (t.op)
            2: res = t.x ^ t.z;
            3: res = t.x & t.z;
            4: res = t.x | t.z;
            default: ;
        endcase
        m_sticky = (t.clr ? 8'h00 : m_sticky) | (((t.op == 0) || (t.op == 5)) ? co : 8'h00);
        m_s      = res;
        m_co     = co;
        m_err    = (t.mode > 3);
    endtask

    task automatic drive(input bit v, input int md, input int o, input logic [31:0] xx,
                         input logic [31:0] yy, input logic [31:0] zz, input bit c,
                         input bit clr);
        reset    = 1'b0;
        ce       = 1'b1;
        in_valid = v;
        mode     = MODE_W'(md);
        op       = 3'(o);
        x_in     = xx;
        y_in     = yy;
        z_in     = zz;
        cin      = c;
        acc_clr  = clr;
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    // One clock: sample inputs, advance the model at the edge, compare #1 later.
    task automatic tick();
        txn_t cur;
        bit   rst_now, ce_now;
        cur.valid = in_valid;
        cur.mode  = mode;
        cur.op    = op;
        cur.x     = x_in;
        cur.y     = y_in;
        cur.z     = z_in;
        cur.cin   = cin;
        cur.clr   = acc_clr;
        rst_now   = reset;
        ce_now    = ce;
        @(posedge clk);
        if (rst_now) begin
            m_s      = 0;
            m_co     = '0;
            m_sticky = '0;
            m_err    = 1'b0;
            m_vld    = 1'b0;
            held     = '{default: 0};
        end else if (ce_now) begin
            if (held.valid) apply(held);
            m_vld = held.valid;
            held  = cur;
        end
        #1;
        check("out_valid", out_valid, m_vld);
        check("S", s_out, m_s[31:0]);
        check("carry_out", carry_out, m_co);
        check("ovf_sticky", ovf_sticky, m_sticky);
        check("mode_err", mode_err, m_err);
    endtask

    initial begin
        held = '{default: 0};
        idle();
        reset = 1'b1;
        tick();
        tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_S", s_out, 32'h0);
        check("rst_sticky", ovf_sticky, 8'h00);

        // Mode 0 full-width carry.
        idle();
        tick();
        drive(1'b1, 0, 0, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        check("m0_valid", out_valid, 1'b1);
        check("m0_S", s_out, 32'h0000_0000);
        check("m0_carry", carry_out, 8'h80);

        // Mode 3 lane isolation.
        drive(1'b1, 3, 0, 32'h8888_8888, 32'h8888_8888, 32'h0, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        check("m3_S", s_out, 32'h0000_0001);
        check("m3_carry", carry_out, 8'hFF);
        check("m3_sticky", ovf_sticky, 8'hFF);

        // Mode 1 borrow.
        drive(1'b1, 1, 1, 32'h0001_0004, 32'h0, 32'h0005_0003, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        check("m1_S", s_out, 32'h0004_FFFF);
        check("m1_borrow", carry_out, 8'h08);

        // Accumulate chain with no bubbles.
        drive(1'b1, 0, 5, 32'd1, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 0, 5, 32'd2, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        check("acc1_S", s_out, 32'd1);
        check("acc1_sticky", ovf_sticky, 8'h00);
        drive(1'b1, 0, 5, 32'd3, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        check("acc2_S", s_out, 32'd3);
        idle();
        tick();
        check("acc3_S", s_out, 32'd6);
        check("acc3_valid", out_valid, 1'b1);

        // Illegal mode behaves as mode 0.
        drive(1'b1, 4, 0, 32'h0001_0000, 32'h0, 32'h0000_FFFF, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        check("ill_S", s_out, 32'h0002_0000);
        check("ill_carry", carry_out, 8'h00);
        check("ill_err", mode_err, 1'b1);

        // Stall mid-stream: everything frozen while ce is low.
        drive(1'b1, 2, 0, 32'h1234_5678, 32'h1111_1111, 32'h0F0F_0F0F, 1'b1, 1'b0);
        tick();
        drive(1'b1, 3, 1, 32'hABCD_EF01, 32'h0, 32'h5555_5555, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 0, 2, $urandom(), $urandom(), $urandom(), 1'b1, 1'b1);
            ce = 1'b0;
            tick();
        end
        drive(1'b1, 1, 5, 32'h0000_0003, 32'h0001_0000, 32'h0, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        tick();

        // Reset with two transactions in flight.
        drive(1'b1, 0, 0, 32'h0000_0010, 32'h0, 32'h0000_0001, 1'b0, 1'b0);
        tick();
        drive(1'b1, 0, 0, 32'h0000_0020, 32'h0, 32'h0000_0002, 1'b0, 1'b0);
        tick();
        drive(1'b1, 0, 0, 32'h0000_0040, 32'h0, 32'h0000_0004, 1'b0, 1'b0);
        reset = 1'b1;
        ce    = 1'b0;
        tick();
        check("flush_valid", out_valid, 1'b0);
        check("flush_S", s_out, 32'h0);
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_late_valid", out_valid, 1'b0);
        end

        // Accumulator seed is zero after reset.
        drive(1'b1, 0, 5, 32'd5, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        check("seed_S", s_out, 32'd5);

        // Randomized traffic, including reserved ops, illegal modes, stalls
        // and occasional resets.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 7),
                  $urandom(), $urandom(), $urandom(), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 5) == 0) begin
                x_in = 32'hFFFF_FFFF;
            end
            ce    = ($urandom_range(0, 6) != 0);
            reset = ($urandom_range(0, 49) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_simd_pipelined_param.md
ALU_SIMD_PIPELINED_PARAM -- requirements
Module: alu_simd_pipelined_param

Interface
REQ-001 The block SHALL have one clock, clk; reset is synchronous and active-high, named reset.
REQ-002 Parameter SEG_W, default 4: bits per segment.
REQ-003 Parameter NUM_SEG, default 8: segment count; a power of two, at least 2.
REQ-004 Parameter REG_IN, default 1: when 1, inputs are registered and latency is 2; when 0, latency is 1.
REQ-005 Derived values: N = SEG_W*NUM_SEG, and MODE_W = clog2(NUM_SEG)+1.
REQ-006 Port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-007 Port reset, input, 1 bit: synchronous active-high reset.
REQ-008 Port ce, input, 1 bit: clock enable for every register in the block.
REQ-009 Port in_valid, input, 1 bit: the current input set is a transaction.
REQ-010 Port mode, input, MODE_W bits: SIMD split m; the word is divided into 2^m lanes of NUM_SEG/2^m segments each.
REQ-011 Port op, input, 3 bits: 000 add, 001 sub, 010 xor, 011 and, 100 or, 101 acc; 110 and 111 are reserved.
REQ-012 Ports X, Y and Z, input, N bits each: operands.
REQ-013 Port CIN, input, 1 bit: carry into lane 0 only.
REQ-014 Port acc_clr, input, 1 bit: zero the accumulator seed for this transaction and clear the sticky flags.
REQ-015 Port out_valid, output, 1 bit: S, carry_out and mode_err hold a completed result.
REQ-016 Port S, output, N bits: registered result.
REQ-017 Port carry_out, output, NUM_SEG bits: lane carry or borrow, placed at each lane's top segment index; all other bits are 0.
REQ-018 Port ovf_sticky, output, NUM_SEG bits: sticky lane carry, at the same bit positions as carry_out.
REQ-019 Port mode_err, output, 1 bit: the transaction used an illegal mode.

Function
REQ-020 Each transaction SHALL capture mode, op, CIN and acc_clr together with its data; the controls may change every cycle.
REQ-021 Carries SHALL propagate between segments inside a lane and be blocked at lane boundaries; lanes other than lane 0 use carry-in 0.
REQ-022 add SHALL compute, per lane of width L bits: S = (Z+X+Y+cin) mod 2^L, with carry = 1 when the true sum is at least 2^L.
REQ-023 sub SHALL compute, per lane: S = (Z-(X+Y+cin)) mod 2^L, with carry = borrow, i.e. 1 when Z < X+Y+cin.
REQ-024 xor, and and or SHALL be bitwise on X and Z; Y and CIN are ignored and carry_out is 0.
REQ-025 acc SHALL compute, per lane: S = P+X+Y+cin, using the carry rules of add.
REQ-026 For acc, P SHALL be the current S register, or 0 if acc_clr is set on that transaction.
REQ-027 Back-to-back acc transactions SHALL chain with no bubbles; the stage that writes S is the only writer of P.
REQ-028 Reserved op codes SHALL produce S = 0 and carry_out = 0, with out_valid still asserted.
REQ-029 mode > clog2(NUM_SEG) SHALL be treated as mode 0, with mode_err = 1 for that result; otherwise mode_err = 0.
REQ-030 out_valid SHALL rise exactly 1+REG_IN ce-enabled cycles after in_valid is sampled.
REQ-031 S, carry_out and mode_err SHALL update only on valid transactions and hold otherwise.
REQ-032 When ce = 0, all registers, including valid and sticky state, SHALL hold.
REQ-033 ovf_sticky SHALL set a lane bit when an add or acc result has carry = 1.
REQ-034 ovf_sticky SHALL clear on reset, or on acc_clr when that transaction reaches the output stage.
REQ-035 If a transaction with acc_clr also carries, its sticky bit SHALL end up set; set wins.
REQ-036 Overflow SHALL wrap modulo 2^L per lane, with no saturation.

Reset
REQ-037 Reset SHALL force S = 0, carry_out = 0, ovf_sticky = 0, mode_err = 0 and out_valid = 0 on the next edge, regardless of ce.
REQ-038 Reset SHALL flush all in-flight transactions; any transaction arriving in the reset cycle is dropped.
REQ-039 After reset the accumulator seed P SHALL be 0.

Verification (defaults: N = 32, REG_IN = 1)
REQ-040 Mode 0 full-width carry: mode 0, add, X = FFFFFFFF, Y = 0, Z = 0, CIN = 1 -> two cycles later S = 00000000, carry_out = 80, out_valid = 1.
REQ-041 Mode 3 lane isolation: mode 3, add, X = Y = 88888888, Z = 0, CIN = 1 -> S = 00000001, carry_out = FF, ovf_sticky = FF.
REQ-042 Mode 1 borrow: mode 1, sub, Z = 00050003, X = 00010004, Y = 0, CIN = 0 -> S = 0004FFFF, carry_out = 08.
REQ-043 Accumulate chain: mode 0, acc, X = 1, 2, 3 on consecutive cycles, acc_clr on the first only -> S = 1, 3, 6 on consecutive cycles.
REQ-044 Stall then reset: ce = 0 for 3 cycles mid-stream -> outputs frozen and resume unchanged; then reset with 2 transactions in flight -> out_valid = 0 and S = 0 next cycle, with no late out_valid.
REQ-045 Illegal mode: mode = 4, add, X = 00010000, Y = 0, Z = 0000FFFF, CIN = 1 -> S = 00020000 (mode 0 behaviour), carry_out = 00, mode_err = 1.
